// File: rtl/buffer_push_arbiter.sv
// Round-robin push arbiter and pull controller for a shared FIFO buffer.
// Tracks its own occupancy so that grant decisions never depend on the buffer's counter.
module buffer_push_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 15,
  parameter int BUFFER_DEPTH = 8,
  parameter int OCC_WIDTH    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          pop_req,
  output logic                          pop_ack,
  input  logic                          flush,
  output logic                          buf_push,
  output logic                          buf_pull,
  output logic [DATA_WIDTH-1:0]         buf_tail,
  output logic [OCC_WIDTH-1:0]          occupancy,
  output logic [1:0]                    state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W = PTR_W + 1;
  localparam logic [OCC_WIDTH-1:0] DEPTH_C = OCC_WIDTH'(BUFFER_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [PTR_W-1:0]       ptr_reg, ptr_next;
  logic [PTR_W-1:0]       winner;
  logic                   found;
  logic                   do_push, do_pull;
  logic [OCC_WIDTH-1:0]   occ_next;
  logic [IDX_W-1:0]       cand;
  logic [DATA_WIDTH-1:0]  slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // First active requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + IDX_W'(k);
      if (cand >= IDX_W'(NUM_REQ)) cand = cand - IDX_W'(NUM_REQ);
      if (!found && req[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  // Full and empty are judged on the pre-edge count, so a same-cycle pull
  // never frees room for a push and a same-cycle push never feeds a pull.
  always_comb begin
    do_push = found && !flush && (state_reg == IDLE || state_reg == ACTIVE)
              && (occupancy < DEPTH_C);
    do_pull = (pop_req || state_reg == FLUSH) && (occupancy != '0);

    occ_next = occupancy;
    case ({do_push, do_pull})
      2'b10:   occ_next = occupancy + OCC_WIDTH'(1);
      2'b01:   occ_next = occupancy - OCC_WIDTH'(1);
      default: occ_next = occupancy;
    endcase

    ptr_next = ptr_reg;
    if (do_push) begin
      if (winner == PTR_W'(NUM_REQ - 1)) ptr_next = '0;
      else                               ptr_next = winner + PTR_W'(1);
    end

    state_next = state_reg;
    if (flush)                                         state_next = FLUSH;
    else if (state_reg == FLUSH && occ_next != '0)     state_next = FLUSH;
    else if (occ_next == '0)                           state_next = IDLE;
    else if (occ_next == DEPTH_C)                      state_next = FULL;
    else                                               state_next = ACTIVE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant     <= '0;
      pop_ack   <= 1'b0;
      buf_push  <= 1'b0;
      buf_pull  <= 1'b0;
      buf_tail  <= '0;
      occupancy <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant     <= do_push ? (NUM_REQ'(1) << winner) : '0;
      buf_push  <= do_push;
      pop_ack   <= do_pull;
      buf_pull  <= do_pull;
      if (do_push) buf_tail <= slice[winner];
      occupancy <= occ_next;
    end
  end

  assign state = state_reg;

endmodule

// File: tb/tb_buffer_push_arbiter.sv
// Randomized and directed bench for buffer_push_arbiter against a queue-free
// behavioural model of the arbitration, occupancy and state rules.
module tb_buffer_push_arbiter;

  localparam int N     = 4;
  localparam int DW    = 15;
  localparam int DEPTH = 8;
  localparam int OW    = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant;
  logic            pop_req;
  logic            pop_ack;
  logic            flush;
  logic            buf_push;
  logic            buf_pull;
  logic [DW-1:0]   buf_tail;
  logic [OW-1:0]   occupancy;
  logic [1:0]      state;

  buffer_push_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .OCC_WIDTH(OW)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .pop_req(pop_req), .pop_ack(pop_ack), .flush(flush),
    .buf_push(buf_push), .buf_pull(buf_pull), .buf_tail(buf_tail),
    .occupancy(occupancy), .state(state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int            m_ptr;
  int            m_occ;
  int            m_state;
  logic [DW-1:0] m_tail;
  logic [N-1:0]  last_grant;
  int            pull_count;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic reset_model();
    m_ptr = 0; m_occ = 0; m_state = 0; m_tail = '0; last_grant = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grant"}, 64'(grant), 64'd0);
    check_eq({tag, "_pop_ack"}, 64'(pop_ack), 64'd0);
    check_eq({tag, "_buf_push"}, 64'(buf_push), 64'd0);
    check_eq({tag, "_buf_pull"}, 64'(buf_pull), 64'd0);
    check_eq({tag, "_buf_tail"}, 64'(buf_tail), 64'd0);
    check_eq({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    check_eq({tag, "_state"}, 64'(state), 64'd0);
  endtask

  // One clock: predict from the inputs about to be sampled, then compare.
  task automatic step(input string tag);
    int           w;
    bit           push, pull;
    logic [N-1:0] eg;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (w < 0 && req[idx]) w = idx;
    end
    push = (w >= 0) && !flush && (m_state == 0 || m_state == 1) && (m_occ < DEPTH);
    pull = (pop_req || m_state == 3) && (m_occ > 0);
    eg = '0;
    if (push) begin
      eg[w]  = 1'b1;
      m_tail = req_data[w*DW +: DW];
      m_ptr  = (w + 1) % N;
    end
    m_occ = m_occ + int'(push) - int'(pull);
    if (flush)             m_state = 3;
    else if (m_state == 3) m_state = (m_occ == 0) ? 0 : 3;
    else                   m_state = (m_occ == 0) ? 0 : ((m_occ == DEPTH) ? 2 : 1);
    last_grant = eg;

    @(posedge clock);
    #1;
    check_eq({tag, "_grant"}, 64'(grant), 64'(eg));
    check_eq({tag, "_buf_push"}, 64'(buf_push), 64'(push));
    check_eq({tag, "_pop_ack"}, 64'(pop_ack), 64'(pull));
    check_eq({tag, "_buf_pull"}, 64'(buf_pull), 64'(pull));
    check_eq({tag, "_buf_tail"}, 64'(buf_tail), 64'(m_tail));
    check_eq({tag, "_occupancy"}, 64'(occupancy), 64'(m_occ));
    check_eq({tag, "_state"}, 64'(state), 64'(m_state));
    $display("%s: req=%b pop=%b flush=%b -> grant=%b ack=%b tail=%h occ=%0d st=%0d",
             tag, req, pop_req, flush, grant, pop_ack, buf_tail, occupancy, state);
  endtask

  task automatic fill_to(input int target);
    req = '1; pop_req = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2*DEPTH && m_occ < target; i++) step("fill");
  endtask

  initial begin
    int saved_ptr;
    reset = 1'b0; req = '0; req_data = '0; pop_req = 1'b0; flush = 1'b0;
    reset_model();
    #12;
    check_reset_outputs("por");
    @(negedge clock);
    reset = 1'b1;

    // Fairness: all four requesting, buffer fills in strict rotation.
    req_data = (N*DW)'({$urandom(), $urandom()});
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step("fair");
      check_eq("fair_onehot", 64'(grant), 64'(4'b0001 << (i % 4)));
      check_eq("fair_tail", 64'(buf_tail), 64'(req_data[(i%4)*DW +: DW]));
    end
    check_eq("fair_full_state", 64'(state), 64'd2);

    // Full refusal: pull goes, push waits a cycle.
    req = 4'b0001; pop_req = 1'b1;
    step("full_ref");
    check_eq("full_ref_grant", 64'(grant), 64'd0);
    check_eq("full_ref_occ", 64'(occupancy), 64'd7);
    pop_req = 1'b0;
    step("full_next");
    check_eq("full_next_grant", 64'(grant), 64'd1);
    check_eq("full_next_occ", 64'(occupancy), 64'd8);

    // Drain to empty, then empty refusal.
    req = '0; pop_req = 1'b1;
    for (int i = 0; i < 2*DEPTH && m_occ > 0; i++) step("drain");
    req = 4'b0100; pop_req = 1'b1;
    step("empty_ref");
    check_eq("empty_ref_grant", 64'(grant), 64'(4'b0100));
    check_eq("empty_ref_ack", 64'(pop_ack), 64'd0);
    check_eq("empty_ref_occ", 64'(occupancy), 64'd1);
    req = '0;
    step("empty_pull");
    check_eq("empty_pull_ack", 64'(pop_ack), 64'd1);
    check_eq("empty_pull_state", 64'(state), 64'd0);

    // Simultaneous push and pull at occupancy 3.
    fill_to(3);
    req = 4'b0010; pop_req = 1'b1;
    step("simul");
    check_eq("simul_grant", 64'(grant), 64'(4'b0010));
    check_eq("simul_ack", 64'(pop_ack), 64'd1);
    check_eq("simul_occ", 64'(occupancy), 64'd3);

    // Flush from occupancy 6 with every producer requesting.
    fill_to(6);
    req = 4'b1111; flush = 1'b1;
    pull_count = 0;
    for (int i = 0; i < 8; i++) begin
      step("flush");
      if (buf_pull) pull_count++;
    end
    check_eq("flush_pulls", 64'(pull_count), 64'd6);
    check_eq("flush_hold_state", 64'(state), 64'd3);
    flush = 1'b0;
    step("flush_exit");
    check_eq("flush_exit_state", 64'(state), 64'd0);
    saved_ptr = m_ptr;
    step("post_flush");
    check_eq("post_flush_grant", 64'(grant), 64'(4'b0001 << saved_ptr));

    // Asynchronous reset between edges with occupancy 5.
    req = '0; pop_req = 1'b1;
    for (int i = 0; i < 2*DEPTH && m_occ > 0; i++) step("drain2");
    fill_to(5);
    check_eq("pre_reset_state", 64'(state), 64'd1);
    req = '1;
    #3 reset = 1'b0;
    #1 check_reset_outputs("async_rst");
    reset_model();
    @(negedge clock);
    reset = 1'b1;
    req = '0; pop_req = 1'b0;

    // Randomized traffic with producers honouring the hold-until-grant handshake.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom());
        end
      end
      pop_req = 1'($urandom_range(0, 1));
      if (flush) flush = ($urandom_range(0, 9) < 7);
      else       flush = ($urandom_range(0, 29) == 0);
      step("rand");
      req = req & ~last_grant;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
